// File: rtl/sms4_pkg.sv
// Shared SMS4 definitions: word type, round count, FSM states, the byte
// S-box table and the linear transform L used by every round.
package sms4_pkg;

    localparam int BWIDTH = 32;
    localparam int NROUND = 32;

    typedef logic [BWIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // SBOX[0] sits in the most significant byte of the first row
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
        128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62,
        128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8,
        128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887,
        128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
        128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
        128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
        128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684,
        128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    // L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24, all rotates are fixed wiring
    function automatic word_t lin_l(input word_t b);
        return b
             ^ {b[29:0], b[31:30]}
             ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]}
             ^ {b[7:0],  b[31:8]};
    endfunction

endpackage

// File: rtl/sms4_round_engine_if.sv
// Block handshake, round-key lookup and result handshake of the SMS4 engine.
// The engine is the slave; the block feeding it (and the key RAM) the master.
interface sms4_round_engine_if;

    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic [127:0] in_block;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_dec, in_block, rk_in, out_ready,
        input  in_ready, rk_idx, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_dec, in_block, rk_in, out_ready,
        output in_ready, rk_idx, out_valid, out_block
    );

endinterface

// File: rtl/sms4_sbox32.sv
// tau: four parallel byte S-box lookups on one 32-bit word, purely combinational.
module sms4_sbox32
    import sms4_pkg::*;
(
    input  word_t mix,
    output word_t tau
);

    // substitute each byte of the word independently
    always_comb begin
        tau = '0;
        for (int i = 0; i < 4; i++) begin
            tau[8*i +: 8] = SBOX[mix[8*i +: 8]];
        end
    end

endmodule

// File: rtl/sms4_round_engine.sv
// Iterative SMS4 round engine: accepts one 128-bit block, runs 32 rounds
// using round keys fetched combinationally from an external key RAM, and
// holds the R-reversed result until downstream accepts it.
// Optional build macro SMS4_PIPE_SBOX_EN registers tau, giving two cycles
// per round (64-cycle latency) with identical results.
module sms4_round_engine
    import sms4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    sms4_round_engine_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] ctr;
    logic       dec;
    word_t      x [4];
    word_t      mix;
    word_t      tau;
    word_t      new_word;
    logic       accept;
    logic       round_step;
    logic       last_round;

`ifdef SMS4_PIPE_SBOX_EN
    logic       phase;
    word_t      tau_q;
`endif

    sms4_sbox32 u_sbox (
        .mix (mix),
        .tau (tau)
    );

    // round function: fold three words with the key, substitute, then L and the fourth word
    always_comb begin
        mix        = x[1] ^ x[2] ^ x[3] ^ bus.rk_in;
        last_round = (ctr == 5'(NROUND - 1));
`ifdef SMS4_PIPE_SBOX_EN
        new_word   = x[0] ^ lin_l(tau_q);
        round_step = (state == ST_ROUND) && phase;
`else
        new_word   = x[0] ^ lin_l(tau);
        round_step = (state == ST_ROUND);
`endif
    end

    // next state plus handshake and key-index outputs
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rk_idx    = 5'd0;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = rst_n;
                accept       = bus.in_valid && rst_n;
                if (accept) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                bus.rk_idx = dec ? (5'(NROUND - 1) - ctr) : ctr;
                if (round_step && last_round) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // working words: load on accept, shift in one new word per round, counter saturates at 31
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '{default: '0};
            ctr <= 5'd0;
            dec <= 1'b0;
        end else if (accept) begin
            x[0] <= bus.in_block[127:96];
            x[1] <= bus.in_block[95:64];
            x[2] <= bus.in_block[63:32];
            x[3] <= bus.in_block[31:0];
            dec  <= bus.in_dec;
            ctr  <= 5'd0;
        end else if (round_step) begin
            x[0] <= x[1];
            x[1] <= x[2];
            x[2] <= x[3];
            x[3] <= new_word;
            if (!last_round) ctr <= ctr + 5'd1;
        end
    end

`ifdef SMS4_PIPE_SBOX_EN
    // split each round into an S-box cycle and a linear/shift cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            tau_q <= '0;
        end else if (accept) begin
            phase <= 1'b0;
        end else if (state == ST_ROUND) begin
            phase <= ~phase;
            if (!phase) tau_q <= tau;
        end
    end
`endif

    // result is the last four words in reverse order, stable while in DONE
    assign bus.out_block = {x[3], x[2], x[1], x[0]};

endmodule

// File: tb/tb_sms4_round_engine.sv
// Scoreboard bench for sms4_round_engine: directed known-answer, probe,
// backpressure and reset tests, then randomized encrypt/decrypt pairs
// checked against an array-based SMS4 reference model with its own key schedule.
module tb_sms4_round_engine;

`ifdef SMS4_PIPE_SBOX_EN
    localparam int PH = 2;
`else
    localparam int PH = 1;
`endif
    localparam int LATENCY = 32 * PH;

    localparam logic [0:255][7:0] TB_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam logic [127:0] VEC_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_CT = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  rk_tab [32];
    logic [127:0] exp_q [$];
    int           pass_cnt = 0;
    int           check_cnt = 0;

    sms4_round_engine_if bus ();

    sms4_round_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rk_in = rk_tab[bus.rk_idx];

    function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [31:0] tb_tau(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = TB_SBOX[w[8*i +: 8]];
        return r;
    endfunction

    // key schedule: K = MK ^ FK, rk(i) = K(i+4) with CK bytes (4i+j)*7 mod 256
    task automatic set_key(input logic [127:0] mk);
        logic [31:0] fk [4];
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            t = tb_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            rk_tab[i] = k[i+4];
        end
    endtask

    // reference cipher over an array of all 36 X words
    function automatic logic [127:0] sm4_model(input logic [127:0] blk, input logic dec);
        logic [31:0] xs [36];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) xs[i] = blk[127 - 32*i -: 32];
        for (int r = 0; r < 32; r++) begin
            t = tb_tau(xs[r+1] ^ xs[r+2] ^ xs[r+3] ^ (dec ? rk_tab[31-r] : rk_tab[r]));
            xs[r+4] = xs[r] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
        end
        return {xs[35], xs[34], xs[33], xs[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // present a block, wait (bounded) for acceptance, optionally queue its expected result
    task automatic applyStimulus(input logic [127:0] blk, input logic dec,
                                 input bit push, input logic [127:0] exp);
        int waited = 0;
        bus.in_block = blk;
        bus.in_dec   = dec;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) checkOutput("accept_timeout", 128'(waited), 128'd0);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 300) checkOutput("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    // monitor: every completed output handshake pops and compares one expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL unexpected_output: got %h expected none", bus.out_block);
            end else begin
                checkOutput("out_block", bus.out_block, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] p;
        logic [127:0] c;
        int           n;
        bit           got;

        bus.in_valid  = 1'b0;
        bus.in_dec    = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b1;
        set_key(128'h0123456789abcdeffedcba9876543210);

        // reset state
        #13;
        checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd0);
        checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("rst_out_block", bus.out_block, 128'd0);
        checkOutput("rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;

        // known-answer encrypt, round-0 probe and latency
        $display("[TB] encrypt vector");
        applyStimulus(VEC_PT, 1'b0, 1'b1, VEC_CT);
        checkOutput("round0_rk_idx", 128'(bus.rk_idx), 128'd0);
        n = 0;
        got = 0;
        while (n < 200 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == PH) checkOutput("round0_x4", 128'(dut.x[3]), 128'h27fad345);
            if (bus.out_valid) got = 1;
        end
        checkOutput("enc_latency", 128'(n), 128'(LATENCY));
        drain();

        // known-answer decrypt with reversed key order
        $display("[TB] decrypt vector");
        applyStimulus(VEC_CT, 1'b1, 1'b1, VEC_PT);
        for (int r = 0; r < 32; r++) begin
            for (int ph = 0; ph < PH; ph++) begin
                checkOutput("dec_rk_idx", 128'(bus.rk_idx), 128'(31 - r));
                @(posedge clk);
                #1;
            end
        end
        drain();

        // backpressure: result held, second block ignored
        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        p = rand128();
        c = sm4_model(p, 1'b0);
        applyStimulus(p, 1'b0, 1'b1, c);
        n = 0;
        while (n < 200 && !bus.out_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_block = rand128();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 128'(bus.out_valid), 128'd1);
            checkOutput("bp_out_block", bus.out_block, c);
            checkOutput("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_idle_in_ready", 128'(bus.in_ready), 128'd1);
            checkOutput("bp_idle_out_valid", 128'(bus.out_valid), 128'd0);
        end

        // reset in the middle of round 15
        $display("[TB] mid-operation reset");
        applyStimulus(rand128(), 1'b0, 1'b0, 128'd0);
        repeat (15 * PH) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("midrst_in_ready", 128'(bus.in_ready), 128'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_rel_in_ready", 128'(bus.in_ready), 128'd1);
        checkOutput("midrst_rel_out_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk);
        #1;
        p = rand128();
        applyStimulus(p, 1'b0, 1'b1, sm4_model(p, 1'b0));
        drain();

        // randomized back-to-back encrypt/decrypt pairs under a fresh key
        $display("[TB] random back-to-back");
        set_key(rand128());
        for (int i = 0; i < 500; i++) begin
            p = rand128();
            c = sm4_model(p, 1'b0);
            applyStimulus(p, 1'b0, 1'b1, c);
            applyStimulus(c, 1'b1, 1'b1, p);
        end
        drain();

        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
